// File: rtl/sequence_ctrl.sv
// Memory-game sequencer: grows a random colour sequence in an external ROM,
// plays it back through a valid/ready display port, then checks player presses.
module sequence_ctrl #(
    parameter int DEPTH  = 16,
    parameter int RD_LAT = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [1:0] rnd,
    input  logic       btn_valid,
    input  logic [1:0] btn_color,
    output logic       show_valid,
    output logic [1:0] show_color,
    input  logic       show_ready,
    output logic       mem_we,
    output logic [3:0] mem_wr_addr,
    output logic [1:0] mem_wr_data,
    output logic [3:0] mem_rd_addr,
    input  logic [1:0] mem_rd_data,
    output logic [4:0] level,
    output logic       busy,
    output logic       game_over,
    output logic       win
);

    typedef enum logic [2:0] {
        IDLE, APPEND, PLAY_RD, PLAY_SHOW, IN_WAIT, IN_RD, IN_CMP
    } state_t;

    localparam int              WAIT_W    = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(RD_LAT);
    localparam logic [4:0]      DEPTH_L   = 5'(DEPTH);

    state_t            state, state_nx;
    logic [4:0]        idx, idx_inc;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        btn_lat, exp_color;
    logic              rd_done, last, match, start_ok;

    // Read data is sampled one cycle after RD_LAT elapses, so the address is
    // held for RD_LAT+1 cycles and is stable for the whole memory latency.
    assign rd_done  = (wait_cnt == WAIT_LAST);
    assign idx_inc  = idx + 5'd1;
    assign last     = (idx_inc == level);
    assign match    = (btn_lat == exp_color);
    assign start_ok = start && !game_over && !win;
    assign busy     = (state != IDLE);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // NOTE: every output of this block gets a default first so no latch can be inferred.
    always_comb begin
        state_nx    = state;
        mem_we      = 1'b0;
        mem_wr_addr = 4'd0;
        mem_wr_data = 2'd0;
        mem_rd_addr = 4'd0;
        show_valid  = 1'b0;
        case (state)
            IDLE:      if (start_ok) state_nx = APPEND;
            APPEND: begin
                mem_we      = 1'b1;
                mem_wr_addr = level[3:0];
                mem_wr_data = rnd;
                state_nx    = PLAY_RD;
            end
            PLAY_RD: begin
                mem_rd_addr = idx[3:0];
                if (rd_done) state_nx = PLAY_SHOW;
            end
            PLAY_SHOW: begin
                show_valid = 1'b1;
                if (show_ready) state_nx = last ? IN_WAIT : PLAY_RD;
            end
            IN_WAIT:   if (btn_valid) state_nx = IN_RD;
            IN_RD: begin
                mem_rd_addr = idx[3:0];
                if (rd_done) state_nx = IN_CMP;
            end
            IN_CMP: begin
                if (!match)                 state_nx = IDLE;
                else if (!last)             state_nx = IN_WAIT;
                else if (level == DEPTH_L)  state_nx = IDLE;
                else                        state_nx = APPEND;
            end
            default:   state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level      <= 5'd0;
            idx        <= 5'd0;
            wait_cnt   <= '0;
            show_color <= 2'd0;
            btn_lat    <= 2'd0;
            exp_color  <= 2'd0;
            game_over  <= 1'b0;
            win        <= 1'b0;
        end else begin
            game_over <= 1'b0;
            win       <= 1'b0;
            case (state)
                IDLE:    if (start_ok) level <= 5'd0;
                APPEND: begin
                    level    <= level + 5'd1;
                    idx      <= 5'd0;
                    wait_cnt <= '0;
                end
                PLAY_RD: begin
                    if (rd_done) begin
                        show_color <= mem_rd_data;
                        wait_cnt   <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                PLAY_SHOW: if (show_ready) idx <= last ? 5'd0 : idx_inc;
                IN_WAIT: begin
                    if (btn_valid) begin
                        btn_lat  <= btn_color;
                        wait_cnt <= '0;
                    end
                end
                IN_RD: begin
                    if (rd_done) begin
                        exp_color <= mem_rd_data;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                IN_CMP: begin
                    if (!match)                game_over <= 1'b1;
                    else if (!last)            idx       <= idx_inc;
                    else if (level == DEPTH_L) win       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sequence_ctrl.sv
// Randomised bench for sequence_ctrl: a transaction-level game model (sequence
// queue, expected event cycles) is compared against the DUT on every negedge.
module tb_sequence_ctrl;

    localparam int DEPTH   = 4;
    localparam int RD_LAT  = 2;
    localparam int CMP_LAT = RD_LAT + 3;   // cycles from an accepted press to its outcome (pulse or next write)
    localparam int NONE    = 32'h7fff_ffff;

    logic       clk_tb = 1'b0;
    logic       rst, start, btn_valid, show_ready;
    logic [1:0] rnd, btn_color, mem_rd_data;
    logic       show_valid, mem_we, busy, game_over, win;
    logic [1:0] show_color, mem_wr_data;
    logic [3:0] mem_wr_addr, mem_rd_addr;
    logic [4:0] level;

    always #5 clk_tb = ~clk_tb;

    sequence_ctrl #(.DEPTH(DEPTH), .RD_LAT(RD_LAT)) dut (
        .clk(clk_tb), .rst(rst), .start(start), .rnd(rnd),
        .btn_valid(btn_valid), .btn_color(btn_color),
        .show_valid(show_valid), .show_color(show_color), .show_ready(show_ready),
        .mem_we(mem_we), .mem_wr_addr(mem_wr_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
        .level(level), .busy(busy), .game_over(game_over), .win(win)
    );

    // sequence_rom: data for an address appears RD_LAT clocks after it is presented
    logic [1:0] rom [16];
    logic [1:0] rd_pipe [RD_LAT];
    always @(posedge clk_tb) begin
        if (mem_we) rom[mem_wr_addr] <= mem_wr_data;
        rd_pipe[0] <= rom[mem_rd_addr];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign mem_rd_data = rd_pipe[RD_LAT-1];

    int cyc = 0;
    always @(posedge clk_tb) cyc <= cyc + 1;

    int         errors = 0, checks = 0;
    logic [1:0] seq [$];
    int         shows = 0;
    bit         round_appended = 0;
    int         exp_append_cyc = NONE, exp_pulse_cyc = NONE, start_cyc = NONE;
    int         game_start_cyc = NONE, game_end_cyc = NONE;
    bit         exp_over = 0;
    logic       prev_sv = 1'b0, prev_rdy = 1'b0;
    logic [1:0] prev_color = 2'd0;
    bit         ready_low = 0, rnd_hold = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic finish_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    endtask

    task automatic fail_out(input string what);
        checks++;
        errors++;
        $display("FAIL timeout %s: no progress by cycle %0d", what, cyc);
        finish_run();
    endtask

    task automatic tick();
        @(posedge clk_tb);
        #1;
    endtask

    // compare process: the model of the game is advanced from events it observes
    always @(negedge clk_tb) begin
        if (rst) begin
            prev_sv = 1'b0;
            shows = 0;
            round_appended = 0;
            seq.delete();
        end else begin
            check("busy", busy, (cyc > game_start_cyc) && (cyc < game_end_cyc));
            check("level", level, seq.size());
            if (mem_we) begin
                check("wr_cycle", cyc, exp_append_cyc);
                check("wr_addr", mem_wr_addr, seq.size());
                check("wr_addr_range", mem_wr_addr < DEPTH, 1);
                check("wr_data", mem_wr_data, rnd);
                check("wr_no_show", show_valid, 0);
                seq.push_back(rnd);
                shows = 0;
                round_appended = 1;
                exp_append_cyc = NONE;
            end else if (cyc == exp_append_cyc) begin
                check("wr_missing", mem_we, 1);
                exp_append_cyc = NONE;
            end
            if (prev_sv && !prev_rdy) begin
                check("show_hold_valid", show_valid, 1);
                check("show_hold_color", show_color, prev_color);
            end
            if (show_valid) begin
                if (shows < seq.size()) check("show_color", show_color, seq[shows]);
                else                    check("show_beyond_level", shows, seq.size() - 1);
                if (show_ready) shows++;
            end
            prev_sv = show_valid;
            prev_rdy = show_ready;
            prev_color = show_color;
            if (game_over || win) begin
                check("pulse_cycle", cyc, exp_pulse_cyc);
                check("game_over", game_over, exp_over);
                check("win", win, !exp_over);
                exp_pulse_cyc = NONE;
            end else if (cyc == exp_pulse_cyc) begin
                check("pulse_missing", game_over | win, 1);
                exp_pulse_cyc = NONE;
            end
            if (cyc == start_cyc) seq.delete();
        end
    end

    initial begin
        show_ready = 1'b0;
        forever begin
            tick();
            show_ready = ready_low ? 1'b0 : ($urandom_range(0, 2) != 0);
        end
    end

    initial begin
        rnd = 2'd0;
        forever begin
            tick();
            if (!rnd_hold) rnd = 2'($urandom);
        end
    end

    task automatic start_game(input int force_rnd);
        if (force_rnd >= 0) begin
            rnd_hold = 1;
            rnd = 2'(force_rnd);
        end
        start = 1'b1;
        start_cyc = cyc;
        game_start_cyc = cyc;
        game_end_cyc = NONE;
        exp_append_cyc = cyc + 1;
        round_appended = 0;
        tick();
        start = 1'b0;
    endtask

    // Runs until the whole sequence has been shown; optionally strobes start/btn meanwhile.
    task automatic wait_playback(input bit spur);
        for (int n = 0; n < 400; n++) begin
            start = 1'b0;
            btn_valid = 1'b0;
            if (round_appended) rnd_hold = 0;
            if (round_appended && shows == seq.size()) return;
            if (spur) begin
                case ($urandom_range(0, 5))
                    0: start = 1'b1;
                    1: begin btn_valid = 1'b1; btn_color = 2'($urandom); end
                    default: ;
                endcase
            end
            tick();
        end
        fail_out("playback");
    endtask

    // outcome: 0 next press, 1 next round, 2 win, 3 game over
    task automatic press(input logic [1:0] col, input int outcome);
        int p = cyc;
        int spur_cyc = p + 1 + $urandom_range(0, CMP_LAT - 2);
        btn_valid = 1'b1;
        btn_color = col;
        case (outcome)
            1: begin
                exp_append_cyc = p + CMP_LAT;
                round_appended = 0;
            end
            2, 3: begin
                exp_pulse_cyc = p + CMP_LAT;
                exp_over = (outcome == 3);
                game_end_cyc = p + CMP_LAT;
            end
            default: ;
        endcase
        tick();
        btn_valid = 1'b0;
        while (cyc < p + CMP_LAT) begin
            if (cyc == spur_cyc) begin
                btn_valid = 1'b1;
                btn_color = ~col;
            end
            tick();
            btn_valid = 1'b0;
        end
    endtask

    task automatic play_rounds(input int mistake_level, input int mistake_pos);
        int L;
        forever begin
            wait_playback(1'b1);
            L = seq.size();
            for (int i = 0; i < L; i++) begin
                repeat ($urandom_range(0, 2)) tick();
                if (L == mistake_level && i == mistake_pos) begin
                    press(seq[i] ^ 2'($urandom_range(1, 3)), 3);
                    return;
                end
                if (i < L - 1)       press(seq[i], 0);
                else if (L == DEPTH) begin
                    press(seq[i], 2);
                    return;
                end else             press(seq[i], 1);
            end
        end
    endtask

    task automatic wait_show();
        for (int n = 0; n < 30; n++) begin
            @(negedge clk_tb);
            if (show_valid) return;
        end
        fail_out("show_valid");
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        errors++;
        finish_run();
    end

    initial begin
        int ml, mp;
        rst = 1'b1; start = 1'b0; btn_valid = 1'b0; btn_color = 2'd0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_show_valid", show_valid, 0);
        check("rst_mem_we", mem_we, 0);
        check("rst_level", level, 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();

        // directed: first append, stalled display, second append address
        ready_low = 1;
        start_game(1);
        @(negedge clk_tb);
        check("A_we", mem_we, 1);
        check("A_wr_addr", mem_wr_addr, 0);
        check("A_wr_data", mem_wr_data, 2'b01);
        wait_show();
        check("A_show_color", show_color, 2'b01);
        check("A_level", level, 1);
        repeat (10) @(negedge clk_tb);
        check("A_stall_valid", show_valid, 1);
        check("A_stall_color", show_color, 2'b01);
        tick();
        ready_low = 0;
        wait_playback(1'b0);
        press(2'b01, 1);
        @(negedge clk_tb);
        check("A_wr_addr2", mem_wr_addr, 1);
        ready_low = 1;
        wait_show();

        // asynchronous reset while a colour is being offered
        @(posedge clk_tb);
        #3;
        rst = 1'b1;
        #1;
        check("R_show_valid", show_valid, 0);
        check("R_show_color", show_color, 0);
        check("R_busy", busy, 0);
        check("R_level", level, 0);
        check("R_mem_we", mem_we, 0);
        check("R_wr_addr", mem_wr_addr, 0);
        check("R_wr_data", mem_wr_data, 0);
        check("R_rd_addr", mem_rd_addr, 0);
        check("R_game_over", game_over, 0);
        check("R_win", win, 0);
        game_start_cyc = NONE; game_end_cyc = NONE;
        exp_append_cyc = NONE; exp_pulse_cyc = NONE; start_cyc = NONE;
        repeat (2) tick();
        rst = 1'b0;
        ready_low = 0;
        btn_valid = 1'b1; btn_color = 2'b01;
        tick();
        btn_valid = 1'b0;
        repeat (3) tick();

        // directed: sequence {01,11}, presses 01 then 10, restart attempt on the pulse
        start_game(1);
        wait_playback(1'b1);
        rnd_hold = 1;
        rnd = 2'b11;
        press(2'b01, 1);
        wait_playback(1'b1);
        press(2'b01, 0);
        press(2'b10, 3);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("B_seq", {seq[0], seq[1]}, 4'b0111);
        repeat (3) tick();
        check("B_level_kept", level, 2);
        check("B_idle", busy, 0);

        // randomised games; the first always plays through to a win
        for (int g = 0; g < 20; g++) begin
            ml = 0;
            mp = 0;
            if (g != 0 && $urandom_range(0, 2) != 0) begin
                ml = $urandom_range(1, DEPTH);
                mp = $urandom_range(0, ml - 1);
            end
            repeat ($urandom_range(1, 4)) begin
                btn_valid = ($urandom_range(0, 3) == 0);
                tick();
                btn_valid = 1'b0;
            end
            start_game(-1);
            play_rounds(ml, mp);
        end
        repeat (4) tick();
        check("end_idle", busy, 0);
        finish_run();
    end

endmodule
